// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and constants for the fetch-PC generator
//   u64          : 64-bit unsigned word
//   pc_state_t   : fetch FSM state {BOOT, RUN, HALT, FAULT}, 2-bit
//   PC_RESET_VEC : default fetch PC after reset
package pc_gen_pkg;

    typedef logic [63:0] u64;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } pc_state_t;

    localparam u64 PC_RESET_VEC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/pc_redir_arb.sv
// rtl/pc_redir_arb.sv - fixed-priority redirect picker, channel 0 highest
//   redir_valid  in  NUM_REDIR       per-channel request
//   redir_target in  NUM_REDIR*XLEN  per-channel target, channel i at [i*XLEN +: XLEN]
//   any_valid    out 1               at least one channel requesting
//   sel          out SEL_W           lowest requesting channel index (0 when none)
//   target       out XLEN            target of the selected channel (0 when none)
module pc_redir_arb #(
    parameter int XLEN      = 64,
    parameter int NUM_REDIR = 3,
    parameter int SEL_W     = 2
) (
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target,
    output logic                      any_valid,
    output logic [SEL_W-1:0]          sel,
    output logic [XLEN-1:0]           target
);

    // Walk from the lowest priority upward so the last hit is the winner.
    always_comb begin
        any_valid = |redir_valid;
        sel       = '0;
        target    = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                sel    = SEL_W'(i);
                target = redir_target[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-PC generator with prioritised redirects and halt/resume
//   Optional build macro: PC_ALIGN_CHECK_EN (misaligned-target fault detection)
//   clk, reset_n      clock, synchronous active-low reset
//   fetch_valid/pc    request offered to fetch; fetch_ready accepts it
//   redir_valid/target per-channel redirect requests, channel 0 highest priority
//   halt_req/resume_req stop issuing / leave HALT at the current PC
//   flush, redir_sel  registered one-cycle pulse and winning channel of a taken redirect
//   state_o           current FSM state
//   fault_valid/pc    misaligned-target fault status (tied 0 without the macro)
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter u64 RESET_VEC  = PC_RESET_VEC,
    parameter int INST_BYTES = 4,
    parameter int NUM_REDIR  = 3,
    localparam int SEL_W     = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic                      fetch_valid,
    output logic [XLEN-1:0]           fetch_pc,
    input  logic                      fetch_ready,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_target,
    input  logic                      halt_req,
    input  logic                      resume_req,
    output logic                      flush,
    output logic [SEL_W-1:0]          redir_sel,
    output logic [1:0]                state_o,
    output logic                      fault_valid,
    output logic [XLEN-1:0]           fault_pc
);

    localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VEC);
    localparam logic [XLEN-1:0] INC    = XLEN'(INST_BYTES);

    pc_state_t       state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic            arb_any;
    logic [SEL_W-1:0] arb_sel;
    logic [XLEN-1:0] arb_target;
    logic            take;
    logic            misaligned;
    logic            accept;

    pc_redir_arb #(
        .XLEN      (XLEN),
        .NUM_REDIR (NUM_REDIR),
        .SEL_W     (SEL_W)
    ) u_arb (
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .any_valid    (arb_any),
        .sel          (arb_sel),
        .target       (arb_target)
    );

`ifdef PC_ALIGN_CHECK_EN
    localparam int ALIGN_W = $clog2(INST_BYTES);
    assign misaligned = |arb_target[ALIGN_W-1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Redirects are dropped in BOOT; in FAULT only channel 0 may act, and
    // since it is the top priority the arbiter's winner is then channel 0.
    always_comb begin
        take = 1'b0;
        if (state == FAULT) begin
            take = redir_valid[0];
        end else if (state != BOOT) begin
            take = arb_any;
        end
    end

    assign accept = fetch_valid & fetch_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (take) begin
            state_nxt = misaligned ? FAULT : RUN;
        end else begin
            case (state)
                BOOT:    state_nxt = RUN;
                RUN:     if (halt_req) state_nxt = HALT;
                HALT:    if (resume_req && !halt_req) state_nxt = RUN;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        fetch_valid = (state == RUN);
        fetch_pc    = pc;
        state_o     = state;
    end

    // A redirect overrides the increment; a halt in the same cycle as an
    // accept still lets the PC advance.
    always_comb begin
        pc_nxt = pc;
        if (take) begin
            if (!misaligned) pc_nxt = arb_target;
        end else if (accept) begin
            pc_nxt = pc + INC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc        <= RST_PC;
            flush     <= 1'b0;
            redir_sel <= '0;
        end else begin
            pc        <= pc_nxt;
            flush     <= take;
            redir_sel <= take ? arb_sel : '0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fault_valid <= 1'b0;
            fault_pc    <= '0;
        end else if (take) begin
            if (misaligned) begin
                fault_valid <= 1'b1;
                fault_pc    <= arb_target;
            end else begin
                fault_valid <= 1'b0;
            end
        end
    end
`else
    assign fault_valid = 1'b0;
    assign fault_pc    = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized bench for pc_gen against a behavioural model
module tb_pc_gen;

    localparam int XLEN = 64;
    localparam int NR   = 3;
    localparam int IB   = 4;
    localparam logic [63:0] RV = 64'h8000_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    // model state encoding follows the documented enum order
    localparam int S_BOOT = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 fetch_ready = 1'b0;
    logic                 halt_req = 1'b0;
    logic                 resume_req = 1'b0;
    logic [NR-1:0]        redir_valid = '0;
    logic [NR*XLEN-1:0]   redir_target = '0;
    logic                 fetch_valid;
    logic [XLEN-1:0]      fetch_pc;
    logic                 flush;
    logic [1:0]           redir_sel;
    logic [1:0]           state_o;
    logic                 fault_valid;
    logic [XLEN-1:0]      fault_pc;

    pc_gen dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .halt_req     (halt_req),
        .resume_req   (resume_req),
        .flush        (flush),
        .redir_sel    (redir_sel),
        .state_o      (state_o),
        .fault_valid  (fault_valid),
        .fault_pc     (fault_pc)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit model_ok = 1'b0;

    logic [63:0] m_pc, m_fpc;
    int          m_st, m_sel;
    bit          m_flush, m_fv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] tgt_of(input int i);
        return redir_target[i*XLEN +: XLEN];
    endfunction

    // Apply current inputs for one clock: predict from the rules, clock, commit.
    task automatic step();
        logic [63:0] n_pc, n_fpc, t;
        int          n_st, n_sel, win;
        bit          n_flush, n_fv, acc;
        n_pc = m_pc; n_fpc = m_fpc; n_st = m_st; n_sel = 0; n_flush = 0; n_fv = m_fv;
        if (!reset_n) begin
            n_pc = RV; n_st = S_BOOT; n_fv = 0; n_fpc = 0;
        end else begin
            acc = (m_st == S_RUN) && fetch_ready;
            win = -1;
            if (m_st == S_FAULT) begin
                if (redir_valid[0]) win = 0;
            end else if (m_st != S_BOOT) begin
                for (int i = 0; i < NR; i++)
                    if (redir_valid[i] && win < 0) win = i;
            end
            if (win >= 0) begin
                n_flush = 1; n_sel = win;
                t = tgt_of(win);
                if (ALIGN && (t % IB) != 0) begin
                    n_st = S_FAULT; n_fv = 1; n_fpc = t;
                end else begin
                    n_pc = t; n_st = S_RUN; n_fv = 0;
                end
            end else begin
                if (acc) n_pc = m_pc + IB;
                if (m_st == S_BOOT) n_st = S_RUN;
                else if (m_st == S_RUN && halt_req) n_st = S_HALT;
                else if (m_st == S_HALT && resume_req && !halt_req) n_st = S_RUN;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_fpc = n_fpc; m_st = n_st; m_sel = n_sel; m_flush = n_flush; m_fv = n_fv;
        model_ok = 1'b1;
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("fetch_valid", fetch_valid, (m_st == S_RUN));
            chk("fetch_pc", fetch_pc, m_pc);
            chk("state", state_o, m_st);
            chk("flush", flush, m_flush);
            if (m_flush) chk("redir_sel", redir_sel, m_sel);
            chk("fault_valid", fault_valid, m_fv);
            chk("fault_pc", fault_pc, m_fpc);
        end
    end

    task automatic set_tgt(input int ch, input logic [63:0] v);
        redir_target[ch*XLEN +: XLEN] = v;
    endtask

    initial begin
        // reset and boot
        reset_n = 0;
        step(); step();
        chk("lit_reset_state", state_o, 0);
        chk("lit_reset_valid", fetch_valid, 0);
        chk("lit_reset_flush", flush, 0);
        reset_n = 1; fetch_ready = 1;
        chk("lit_boot_valid", fetch_valid, 0);
        step();
        chk("lit_t1_pc0", fetch_pc, 64'h8000_0000);
        chk("lit_t1_valid", fetch_valid, 1);
        step();
        chk("lit_t1_pc1", fetch_pc, 64'h8000_0004);
        step();
        chk("lit_t1_pc2", fetch_pc, 64'h8000_0008);
        // stall
        fetch_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lit_t2_hold_pc", fetch_pc, 64'h8000_0008);
            chk("lit_t2_hold_valid", fetch_valid, 1);
        end
        // redirect with simultaneous accept
        fetch_ready = 1; redir_valid = 3'b110;
        set_tgt(1, 64'h8000_1000); set_tgt(2, 64'h8000_2000);
        step();
        chk("lit_t3_pc", fetch_pc, 64'h8000_1000);
        chk("lit_t3_flush", flush, 1);
        chk("lit_t3_sel", redir_sel, 1);
        redir_valid = '0; fetch_ready = 0;
        step();
        chk("lit_t3_flush_clr", flush, 0);
        // halt / resume / redirect from HALT
        halt_req = 1;
        step();
        chk("lit_t4_halt_valid", fetch_valid, 0);
        chk("lit_t4_halt_state", state_o, 2);
        chk("lit_t4_halt_pc", fetch_pc, 64'h8000_1000);
        halt_req = 0; resume_req = 1;
        step();
        chk("lit_t4_resume_state", state_o, 1);
        chk("lit_t4_resume_pc", fetch_pc, 64'h8000_1000);
        resume_req = 0; halt_req = 1;
        step();
        halt_req = 0; redir_valid = 3'b100;
        step();
        chk("lit_t4_redir_state", state_o, 1);
        chk("lit_t4_redir_pc", fetch_pc, 64'h8000_2000);
        chk("lit_t4_redir_sel", redir_sel, 2);
        // wrap and mid-stream reset
        redir_valid = 3'b001; set_tgt(0, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("lit_t5_top_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        redir_valid = '0; fetch_ready = 1;
        step();
        chk("lit_t5_wrap_pc", fetch_pc, 64'h0);
        reset_n = 0;
        step();
        chk("lit_t5_rst_pc", fetch_pc, 64'h8000_0000);
        chk("lit_t5_rst_state", state_o, 0);
        reset_n = 1; fetch_ready = 0;
        step();
`ifdef PC_ALIGN_CHECK_EN
        redir_valid = 3'b010; set_tgt(1, 64'h8000_0002);
        step();
        chk("lit_t6_fault_state", state_o, 3);
        chk("lit_t6_fault_valid", fault_valid, 1);
        chk("lit_t6_fault_pc", fault_pc, 64'h8000_0002);
        chk("lit_t6_fetch_valid", fetch_valid, 0);
        redir_valid = 3'b100; set_tgt(2, 64'h8000_3000);
        step();
        chk("lit_t6_ignored_state", state_o, 3);
        chk("lit_t6_ignored_pc", fetch_pc, 64'h8000_0000);
        redir_valid = 3'b001; set_tgt(0, 64'h8000_0100);
        step();
        chk("lit_t6_exit_state", state_o, 1);
        chk("lit_t6_exit_fv", fault_valid, 0);
        chk("lit_t6_exit_pc", fetch_pc, 64'h8000_0100);
        redir_valid = '0;
`endif
        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            reset_n     = ($urandom_range(0, 199) != 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            halt_req    = ($urandom_range(0, 15) == 0);
            resume_req  = ($urandom_range(0, 3) == 0);
            redir_valid = ($urandom_range(0, 5) == 0) ? NR'($urandom_range(1, 7)) : '0;
            for (int ch = 0; ch < NR; ch++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r == 0)      set_tgt(ch, {$urandom, $urandom} | 64'h2);
                else if (r == 1) set_tgt(ch, 64'hFFFF_FFFF_FFFF_FFFC);
                else             set_tgt(ch, {$urandom, $urandom} & ~64'h3);
            end
            step();
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
